// File: rtl/hazard_stall_controller_if.sv
// Bus bundle for hazard_stall_controller: instruction-side inputs and stall-side outputs.
// Handshake: ins is only decoded in a cycle where ins_valid=1; resume is a single-cycle
// pulse that matters only while halted; Stall is valid combinationally in the same cycle,
// Stall_pm is its one-cycle-delayed copy. dbg_state exposes the controller FSM state.
interface hazard_stall_controller_if #(
  parameter int INS_W = 24
);
  logic [INS_W-1:0] ins;
  logic             ins_valid;
  logic             resume;
  logic             Stall;
  logic             Stall_pm;
  logic             halted;
  logic [15:0]      stall_cycles;
  logic [1:0]       dbg_state;

  modport master (
    output ins, ins_valid, resume,
    input  Stall, Stall_pm, halted, stall_cycles, dbg_state
  );

  modport slave (
    input  ins, ins_valid, resume,
    output Stall, Stall_pm, halted, stall_cycles, dbg_state
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: decodes the IR opcode and stalls the pipeline for halt,
// jump and load-use hazards. Each event stalls for its configured number of cycles
// (detection cycle included) and is followed by one GRACE cycle so the held
// instruction can advance without re-triggering. Halt holds until a resume pulse.
// Optional macro STALL_PERF_CNT_EN builds a saturating 16-bit stall-cycle counter;
// without it stall_cycles is tied to zero.
module hazard_stall_controller #(
  parameter int             INS_W         = 24,
  parameter int             OPC_LSB       = 19,
  parameter int             OPC_W         = 5,
  parameter logic [OPC_W-1:0] OPC_HLT     = 5'b10001,
  parameter logic [OPC_W-1:0] OPC_LD      = 5'b10100,
  parameter logic [OPC_W-1:0] JMP_MASK    = 5'b11100,
  parameter logic [OPC_W-1:0] JMP_VAL     = 5'b11100,
  parameter int             LD_STALL_CYC  = 1,
  parameter int             JMP_STALL_CYC = 2
) (
  input logic                      clk,
  input logic                      reset,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2,
    ST_GRACE = 2'd3
  } state_t;

  // Counter preload leaves cnt==0 on the last STALL cycle of the event.
  localparam logic [3:0] LD_CNT_INIT  = 4'((LD_STALL_CYC  >= 2) ? LD_STALL_CYC  - 2 : 0);
  localparam logic [3:0] JMP_CNT_INIT = 4'((JMP_STALL_CYC >= 2) ? JMP_STALL_CYC - 2 : 0);
  localparam bit         LD_ONE       = (LD_STALL_CYC  == 1);
  localparam bit         JMP_ONE      = (JMP_STALL_CYC == 1);

  // Elaboration-time legality checks on the configuration.
  if (LD_STALL_CYC < 1 || LD_STALL_CYC > 15) begin : g_bad_ld
    $error("hazard_stall_controller: LD_STALL_CYC out of range 1..15");
  end
  if (JMP_STALL_CYC < 1 || JMP_STALL_CYC > 15) begin : g_bad_jmp
    $error("hazard_stall_controller: JMP_STALL_CYC out of range 1..15");
  end
  if (OPC_LSB + OPC_W > INS_W) begin : g_bad_opc
    $error("hazard_stall_controller: opcode field exceeds instruction width");
  end

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_halted;
  logic       r_stall_pm;

  logic [OPC_W-1:0] w_opc;
  logic             w_hlt;
  logic             w_jmp;
  logic             w_ld;
  logic             w_stall;
  logic             w_unused_ins;

  assign w_opc        = bus.ins[OPC_LSB +: OPC_W];
  // Only the opcode field is decoded; the rest of the IR is intentionally ignored.
  assign w_unused_ins = ^bus.ins;

  // Prioritised hazard decode: HLT beats JMP beats LD, all gated by ins_valid.
  always_comb begin
    w_hlt = bus.ins_valid && (w_opc == OPC_HLT);
    w_jmp = bus.ins_valid && !w_hlt && ((w_opc & JMP_MASK) == JMP_VAL);
    w_ld  = bus.ins_valid && !w_hlt && !w_jmp && (w_opc == OPC_LD);
  end

  // Stall is combinational: decode in RUN, held in STALL/HALT, released in GRACE, killed by reset.
  always_comb begin
    w_stall = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RUN:   w_stall = w_hlt || w_jmp || w_ld;
        ST_STALL: w_stall = 1'b1;
        ST_HALT:  w_stall = 1'b1;
        default:  w_stall = 1'b0;
      endcase
    end
  end

  // Controller FSM with stall down-counter and registered halted flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_cnt    <= 4'd0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hlt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_jmp) begin
            if (JMP_ONE) begin
              r_state <= ST_GRACE;
            end else begin
              r_state <= ST_STALL;
              r_cnt   <= JMP_CNT_INIT;
            end
          end else if (w_ld) begin
            if (LD_ONE) begin
              r_state <= ST_GRACE;
            end else begin
              r_state <= ST_STALL;
              r_cnt   <= LD_CNT_INIT;
            end
          end
        end
        ST_STALL: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_GRACE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HALT: begin
          if (bus.resume) begin
            r_state  <= ST_GRACE;
            r_halted <= 1'b0;
          end
        end
        ST_GRACE: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle-delayed stall for program memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_pm <= 1'b0;
    end else begin
      r_stall_pm <= w_stall;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of cycles in which the pipeline was stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 16'h0000;
    end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'h0001;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = 16'h0000;
`endif

  assign bus.Stall     = w_stall;
  assign bus.Stall_pm  = r_stall_pm;
  assign bus.halted    = r_halted && !reset;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller. Three instances cover the default configuration,
// longer stalls (LD=3, JMP=4) and an overlapping jump class (mask=val=10000).
// The reference model treats each hazard as a scheduled list of future Stall values.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_controller_if bus0 ();
  hazard_stall_controller_if bus1 ();
  hazard_stall_controller_if bus2 ();

  hazard_stall_controller dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  hazard_stall_controller #(.LD_STALL_CYC(3), .JMP_STALL_CYC(4))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  hazard_stall_controller #(.JMP_MASK(5'b10000), .JMP_VAL(5'b10000))
    dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  // Driven stimulus, routed to the instance under test; the others see idle inputs.
  int          cur_dut = 0;
  logic [23:0] t_ins = '0;
  logic        t_valid = 1'b0;
  logic        t_resume = 1'b0;

  assign bus0.ins       = (cur_dut == 0) ? t_ins : 24'h0;
  assign bus0.ins_valid = (cur_dut == 0) ? t_valid : 1'b0;
  assign bus0.resume    = (cur_dut == 0) ? t_resume : 1'b0;
  assign bus1.ins       = (cur_dut == 1) ? t_ins : 24'h0;
  assign bus1.ins_valid = (cur_dut == 1) ? t_valid : 1'b0;
  assign bus1.resume    = (cur_dut == 1) ? t_resume : 1'b0;
  assign bus2.ins       = (cur_dut == 2) ? t_ins : 24'h0;
  assign bus2.ins_valid = (cur_dut == 2) ? t_valid : 1'b0;
  assign bus2.resume    = (cur_dut == 2) ? t_resume : 1'b0;

  logic        o_stall, o_pm, o_halted;
  logic [15:0] o_cyc;
  assign o_stall  = (cur_dut == 0) ? bus0.Stall    : (cur_dut == 1) ? bus1.Stall    : bus2.Stall;
  assign o_pm     = (cur_dut == 0) ? bus0.Stall_pm : (cur_dut == 1) ? bus1.Stall_pm : bus2.Stall_pm;
  assign o_halted = (cur_dut == 0) ? bus0.halted   : (cur_dut == 1) ? bus1.halted   : bus2.halted;
  assign o_cyc    = (cur_dut == 0) ? bus0.stall_cycles :
                    (cur_dut == 1) ? bus1.stall_cycles : bus2.stall_cycles;

  // Configuration of the instance currently modelled.
  logic [4:0] p_hlt = 5'b10001;
  logic [4:0] p_ld  = 5'b10100;
  logic [4:0] p_jm  = 5'b11100;
  logic [4:0] p_jv  = 5'b11100;
  int         p_ldn = 1;
  int         p_jn  = 2;

  // Reference model state and per-cycle expectations.
  logic        exp_q[$];
  logic        m_halted = 1'b0;
  logic        m_pm = 1'b0;
  logic [15:0] m_cyc = 16'h0;
  logic        exp_stall, exp_pm, exp_halted;
  logic [15:0] exp_cyc;

  int checks = 0;
  int failures = 0;

  task automatic select_dut(input int d);
    cur_dut = d;
    p_jm  = (d == 2) ? 5'b10000 : 5'b11100;
    p_jv  = (d == 2) ? 5'b10000 : 5'b11100;
    p_ldn = (d == 1) ? 3 : 1;
    p_jn  = (d == 1) ? 4 : 2;
  endtask

  // An event of n stall cycles: the detection cycle is already counted, then n-1 more, then grace.
  task automatic schedule(input int n);
    for (int i = 1; i < n; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
  endtask

  // Drive one cycle of inputs and advance the reference model by one clock.
  task automatic drive(input logic [23:0] ins, input logic v, input logic res, input logic rst);
    logic [4:0] opc;
    @(negedge clk);
    t_ins = ins; t_valid = v; t_resume = res; reset = rst;
    #1;
    exp_pm     = m_pm;
    exp_cyc    = m_cyc;
    exp_halted = rst ? 1'b0 : m_halted;
    opc        = ins[23:19];
    exp_stall  = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_halted = 1'b0;
    end else if (m_halted) begin
      exp_stall = 1'b1;
      if (res) begin
        m_halted = 1'b0;
        exp_q.push_back(1'b0);
      end
    end else if (exp_q.size() > 0) begin
      exp_stall = exp_q.pop_front();
    end else if (v) begin
      if (opc == p_hlt) begin
        exp_stall = 1'b1;
        m_halted  = 1'b1;
      end else if ((opc & p_jm) == p_jv) begin
        exp_stall = 1'b1;
        schedule(p_jn);
      end else if (opc == p_ld) begin
        exp_stall = 1'b1;
        schedule(p_ldn);
      end
    end
    m_pm = rst ? 1'b0 : exp_stall;
`ifdef STALL_PERF_CNT_EN
    if (rst) m_cyc = 16'h0;
    else if (exp_stall && m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'h1;
`endif
  endtask

  task automatic test_reset();
    select_dut(0);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_stall, o_pm, o_halted, o_cyc} !== 19'h0) begin
      failures++;
      $display("FAIL reset_state: got stall=%b pm=%b halted=%b cyc=%h want all zero",
               o_stall, o_pm, o_halted, o_cyc);
    end
  endtask

  task automatic test_ld_held();
    logic seen[$];
    select_dut(0);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(24'hA00000, 1'b1, 1'b0, 1'b0);
      seen.push_back(o_stall);
      checks++;
      if ({o_stall, o_pm, o_halted, o_cyc} !== {exp_stall, exp_pm, exp_halted, exp_cyc}) begin
        failures++;
        $display("FAIL ld_held c%0d: got s=%b pm=%b h=%b cyc=%h want s=%b pm=%b h=%b cyc=%h", i,
                 o_stall, o_pm, o_halted, o_cyc, exp_stall, exp_pm, exp_halted, exp_cyc);
      end
    end
    checks++;
    if ({seen[0], seen[1], seen[2]} !== 3'b101) begin
      failures++;
      $display("FAIL ld_pattern: got %b%b%b want 101", seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_jmp(input int d, input int n);
    int ones;
    int first_zero;
    select_dut(d);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    ones = 0;
    first_zero = -1;
    for (int i = 0; i < 8; i++) begin
      drive((i == 0) ? 24'hE00000 : 24'h000000, 1'b1, 1'b0, 1'b0);
      if (o_stall) ones++;
      else if (first_zero < 0) first_zero = i;
      checks++;
      if ({o_stall, o_pm, o_halted, o_cyc} !== {exp_stall, exp_pm, exp_halted, exp_cyc}) begin
        failures++;
        $display("FAIL jmp%0d c%0d: got s=%b pm=%b h=%b cyc=%h want s=%b pm=%b h=%b cyc=%h", n, i,
                 o_stall, o_pm, o_halted, o_cyc, exp_stall, exp_pm, exp_halted, exp_cyc);
      end
    end
    checks++;
    if (ones != n || first_zero != n) begin
      failures++;
      $display("FAIL jmp%0d_length: got %0d stall cycles (first low at %0d) want %0d", n, ones,
               first_zero, n);
    end
  endtask

  task automatic test_halt();
    select_dut(0);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      drive(24'h880000, 1'b1, (i == 20), 1'b0);
      checks++;
      if ({o_stall, o_pm, o_halted, o_cyc} !== {exp_stall, exp_pm, exp_halted, exp_cyc}) begin
        failures++;
        $display("FAIL halt c%0d: got s=%b pm=%b h=%b cyc=%h want s=%b pm=%b h=%b cyc=%h", i,
                 o_stall, o_pm, o_halted, o_cyc, exp_stall, exp_pm, exp_halted, exp_cyc);
      end
      if (i == 21 || i == 23) begin
        checks++;
        if ({o_stall, o_halted} !== ((i == 21) ? 2'b00 : 2'b11)) begin
          failures++;
          $display("FAIL halt_resume c%0d: got s=%b h=%b", i, o_stall, o_halted);
        end
      end
    end
  endtask

  task automatic test_priority_valid();
    select_dut(2);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'h880000, 1'b1, 1'b0, 1'b0);
    drive(24'h880000, 1'b1, 1'b0, 1'b0);
    drive(24'h000000, 1'b1, 1'b0, 1'b0);
    drive(24'h000000, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_stall, o_halted} !== 2'b11) begin
      failures++;
      $display("FAIL priority_hlt: got s=%b h=%b want s=1 h=1", o_stall, o_halted);
    end
    select_dut(0);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(24'hA00000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_stall !== 1'b0 || o_pm !== 1'b0) begin
        failures++;
        $display("FAIL invalid_ld c%0d: got s=%b pm=%b want 0 0", i, o_stall, o_pm);
      end
    end
  endtask

  task automatic test_reset_mid();
    select_dut(1);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'hE00000, 1'b1, 1'b0, 1'b0);
    drive(24'hE00000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (o_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_stall: got %b want 0", o_stall);
    end
    // Back in RUN with no grace: the held jump re-triggers immediately.
    drive(24'hE00000, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_stall, o_pm} !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid_after: got s=%b pm=%b want s=1 pm=0", o_stall, o_pm);
    end
  endtask

  task automatic test_random();
    logic [4:0] opc;
    logic [23:0] ins;
    for (int seg = 0; seg < 3; seg++) begin
      select_dut(seg);
      drive(24'h0, 1'b0, 1'b0, 1'b1);
      ins = 24'h0;
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 4))
            0: opc = 5'b10001;
            1: opc = 5'b10100;
            2: opc = {3'b111, 2'($urandom)};
            3: opc = 5'($urandom);
            default: opc = 5'b00000;
          endcase
          ins = {opc, 19'($urandom)};
        end
        drive(ins, ($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 79) == 0));
        checks++;
        if ({o_stall, o_pm, o_halted, o_cyc} !== {exp_stall, exp_pm, exp_halted, exp_cyc}) begin
          failures++;
          $display("FAIL random d%0d c%0d ins=%h: got s=%b pm=%b h=%b cyc=%h want s=%b pm=%b h=%b cyc=%h",
                   seg, i, ins, o_stall, o_pm, o_halted, o_cyc, exp_stall, exp_pm, exp_halted, exp_cyc);
        end
      end
    end
  endtask

  task automatic test_perf_counter();
    logic [15:0] want;
    select_dut(0);
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'hA00000, 1'b1, 1'b0, 1'b0);
    drive(24'h000000, 1'b1, 1'b0, 1'b0);
    drive(24'hE00000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(24'h000000, 1'b1, 1'b0, 1'b0);
    drive(24'h880000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(24'h000000, 1'b1, 1'b0, 1'b0);
    drive(24'h000000, 1'b1, 1'b1, 1'b0);
    drive(24'h000000, 1'b1, 1'b0, 1'b0);
`ifdef STALL_PERF_CNT_EN
    want = 16'd11;
`else
    want = 16'd0;
`endif
    checks++;
    if (o_cyc !== want || o_cyc !== exp_cyc) begin
      failures++;
      $display("FAIL perf_count: got %0d want %0d", o_cyc, want);
    end
`ifdef STALL_PERF_CNT_EN
    drive(24'h880000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) drive(24'h880000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_cyc !== 16'hFFFF || o_stall !== 1'b1) begin
      failures++;
      $display("FAIL perf_saturate: got cyc=%h s=%b want cyc=ffff s=1", o_cyc, o_stall);
    end
    drive(24'h0, 1'b0, 1'b0, 1'b1);
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_cyc !== 16'h0) begin
      failures++;
      $display("FAIL perf_reset_clear: got %h want 0", o_cyc);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_ld_held();
    test_jmp(0, 2);
    test_jmp(1, 4);
    test_halt();
    test_priority_valid();
    test_reset_mid();
    test_random();
    test_perf_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
